// File: rtl/pc_ir_unit_pkg.sv
// Shared constants for the fetch-side datapath of the multicycle MIPS core:
// PC source select encodings and the opcodes the controller decodes.
package pc_ir_unit_pkg;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_HOLD   = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;

endpackage

// File: rtl/pc_ir_unit_if.sv
// Bundle of controller strobes, ALU/memory inputs and latched fields
// exchanged between the fetch unit and the rest of the core.
interface pc_ir_unit_if #(parameter int WIDTH = 32);

    logic             PCWrite;
    logic             Branch;
    logic [1:0]       PCSrc;
    logic             IRWrite;
    logic             IorD;
    logic             Ori;
    logic             zero;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] mem_rdata;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] mdr;
    logic [5:0]       Opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [5:0]       funct;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] instr_count;

    // Controller / datapath side that drives strobes and observes fields
    modport master (
        output PCWrite, Branch, PCSrc, IRWrite, IorD, Ori, zero, alu_result, mem_rdata,
        input  mem_addr, pc, alu_out, mdr, Opcode, rs, rt, rd, funct, imm_ext, instr_count
    );

    // The fetch unit itself
    modport slave (
        input  PCWrite, Branch, PCSrc, IRWrite, IorD, Ori, zero, alu_result, mem_rdata,
        output mem_addr, pc, alu_out, mdr, Opcode, rs, rt, rd, funct, imm_ext, instr_count
    );

endinterface

// File: rtl/pc_ir_unit_en_reg.sv
// Generic register with load enable and asynchronous active-low reset to a
// configurable value; used for every architectural register of the fetch unit.
module en_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // Load d_i when enabled, otherwise hold; reset wins immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Fetch-side datapath: PC, IR, MDR, ALUOut and an instruction counter, with
// PC enable / source selection and decoding of the latched instruction fields.
module pc_ir_unit
    import pc_ir_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    pc_ir_unit_if.slave  bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] mdr_q;
    logic [WIDTH-1:0] alu_out_q;
    logic [WIDTH-1:0] instr_count_q, instr_count_d;
    logic             pc_en;
    logic             pc_load;

    // A taken branch is an ordinary PC load; the HOLD source suppresses any load
    assign pc_en         = bus.PCWrite | (bus.Branch & bus.zero);
    assign pc_load       = pc_en && (bus.PCSrc != PCSRC_HOLD);
    assign instr_count_d = instr_count_q + WIDTH'(1);

    // Select the next PC; the jump target keeps the top nibble of the already-incremented PC
    always_comb begin
        pc_d = pc_q;
        unique case (bus.PCSrc)
            PCSRC_ALU:    pc_d = bus.alu_result;
            PCSRC_ALUOUT: pc_d = alu_out_q;
            PCSRC_JUMP:   pc_d = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};
            PCSRC_HOLD:   pc_d = pc_q;
            default:      pc_d = pc_q;
        endcase
    end

    en_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst_n(rst_n), .en_i(pc_load), .d_i(pc_d), .q_o(pc_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_ir (
        .clk(clk), .rst_n(rst_n), .en_i(bus.IRWrite), .d_i(bus.mem_rdata), .q_o(ir_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_mdr (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(bus.mem_rdata), .q_o(mdr_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_alu_out (
        .clk(clk), .rst_n(rst_n), .en_i(1'b1), .d_i(bus.alu_result), .q_o(alu_out_q)
    );

    en_reg #(.WIDTH(WIDTH), .RESET_VAL('0)) u_instr_count (
        .clk(clk), .rst_n(rst_n), .en_i(bus.IRWrite), .d_i(instr_count_d), .q_o(instr_count_q)
    );

    assign bus.pc          = pc_q;
    assign bus.alu_out     = alu_out_q;
    assign bus.mdr         = mdr_q;
    assign bus.instr_count = instr_count_q;
    assign bus.mem_addr    = bus.IorD ? alu_out_q : pc_q;

    assign bus.Opcode  = ir_q[31:26];
    assign bus.rs      = ir_q[25:21];
    assign bus.rt      = ir_q[20:16];
    assign bus.rd      = ir_q[15:11];
    assign bus.funct   = ir_q[5:0];
    assign bus.imm_ext = bus.Ori ? {16'b0, ir_q[15:0]} : {{16{ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_pc_ir_unit.sv
// Bench for the fetch-side datapath: a table of controller steps with the
// register state expected after each edge, plus an asynchronous reset sequence.
module tb_pc_ir_unit;

    typedef struct packed {
        logic        pcWrite;
        logic        branch;
        logic [1:0]  pcSrc;
        logic        irWrite;
        logic        iorD;
        logic        ori;
        logic        zero;
        logic [31:0] aluResult;
        logic [31:0] memRdata;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [31:0] immExt;
        logic [31:0] aluOut;
        logic [31:0] mdr;
        logic [31:0] memAddr;
        logic [31:0] instrCount;
    } exp_t;

    typedef struct packed {
        stim_t stim;
        exp_t  exp;
    } vec_t;

    localparam int NUM_VECS = 11;

    logic clk;
    logic rst_n;
    int   passCount;
    int   totalCount;
    vec_t vecs [NUM_VECS];
    exp_t expQueue [$];

    pc_ir_unit_if #(.WIDTH(32)) bus ();

    pc_ir_unit #(.WIDTH(32), .RESET_PC(32'h0040_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic pcw, input logic br, input logic [1:0] src,
                                input logic irw, input logic iord, input logic ori, input logic z,
                                input logic [31:0] alu, input logic [31:0] mem,
                                input logic [31:0] ePc, input logic [5:0] eOp, input logic [4:0] eRs,
                                input logic [4:0] eRt, input logic [4:0] eRd, input logic [5:0] eFn,
                                input logic [31:0] eImm, input logic [31:0] eAluOut,
                                input logic [31:0] eMdr, input logic [31:0] eAddr,
                                input logic [31:0] eCnt);
        vec_t v;
        v.stim = '{pcw, br, src, irw, iord, ori, z, alu, mem};
        v.exp  = '{ePc, eOp, eRs, eRt, eRd, eFn, eImm, eAluOut, eMdr, eAddr, eCnt};
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] required);
        totalCount++;
        if (actual === required) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic driveStim(input stim_t s);
        bus.PCWrite    = s.pcWrite;
        bus.Branch     = s.branch;
        bus.PCSrc      = s.pcSrc;
        bus.IRWrite    = s.irWrite;
        bus.IorD       = s.iorD;
        bus.Ori        = s.ori;
        bus.zero       = s.zero;
        bus.alu_result = s.aluResult;
        bus.mem_rdata  = s.memRdata;
    endtask

    // Drive one controller step away from the edge and queue the state expected after it
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        driveStim(v.stim);
        expQueue.push_back(v.exp);
    endtask

    // After the edge, pop the oldest expectation and compare every observable output
    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        totalCount++;
        if (expQueue.size() == 0) begin
            $display("[TB] FAIL %s_queue actual=empty required=entry", tag);
            return;
        end
        passCount++;
        e = expQueue.pop_front();
        checkVal({tag, "_pc"},         bus.pc,                 e.pc);
        checkVal({tag, "_opcode"},     {26'b0, bus.Opcode},    {26'b0, e.opcode});
        checkVal({tag, "_rs"},         {27'b0, bus.rs},        {27'b0, e.rs});
        checkVal({tag, "_rt"},         {27'b0, bus.rt},        {27'b0, e.rt});
        checkVal({tag, "_rd"},         {27'b0, bus.rd},        {27'b0, e.rd});
        checkVal({tag, "_funct"},      {26'b0, bus.funct},     {26'b0, e.funct});
        checkVal({tag, "_imm_ext"},    bus.imm_ext,            e.immExt);
        checkVal({tag, "_alu_out"},    bus.alu_out,            e.aluOut);
        checkVal({tag, "_mdr"},        bus.mdr,                e.mdr);
        checkVal({tag, "_mem_addr"},   bus.mem_addr,           e.memAddr);
        checkVal({tag, "_instr_count"}, bus.instr_count,       e.instrCount);
    endtask

    initial begin
        passCount  = 0;
        totalCount = 0;
        rst_n      = 1'b0;
        driveStim('0);

        // Controller steps: FETCH, DECODE, branch not taken/taken, ORI fetch,
        // sign/zero extension, IorD with HOLD, jump, branch with HOLD, R-type fetch
        vecs[0]  = mk(1,0,2'b00,1,0,0,0, 32'h0040_0004, 32'h2008_0005,
                      32'h0040_0004, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 32'h0000_0005,
                      32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 32'd1);
        vecs[1]  = mk(0,0,2'b00,0,0,0,0, 32'h0040_0020, 32'hDEAD_BEEF,
                      32'h0040_0004, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 32'h0000_0005,
                      32'h0040_0020, 32'hDEAD_BEEF, 32'h0040_0004, 32'd1);
        vecs[2]  = mk(0,1,2'b01,0,0,0,0, 32'h0040_0020, 32'h1111_1111,
                      32'h0040_0004, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 32'h0000_0005,
                      32'h0040_0020, 32'h1111_1111, 32'h0040_0004, 32'd1);
        vecs[3]  = mk(0,1,2'b01,0,0,0,1, 32'h0040_0020, 32'h2222_2222,
                      32'h0040_0020, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 32'h0000_0005,
                      32'h0040_0020, 32'h2222_2222, 32'h0040_0020, 32'd1);
        vecs[4]  = mk(1,0,2'b00,1,0,1,0, 32'h0040_0024, 32'h3408_FFFF,
                      32'h0040_0024, 6'h0d, 5'd0, 5'd8, 5'd31, 6'h3F, 32'h0000_FFFF,
                      32'h0040_0024, 32'h3408_FFFF, 32'h0040_0024, 32'd2);
        vecs[5]  = mk(0,0,2'b00,0,0,0,0, 32'h1001_0000, 32'h0000_0000,
                      32'h0040_0024, 6'h0d, 5'd0, 5'd8, 5'd31, 6'h3F, 32'hFFFF_FFFF,
                      32'h1001_0000, 32'h0000_0000, 32'h0040_0024, 32'd2);
        vecs[6]  = mk(1,0,2'b11,0,1,0,0, 32'h1001_0000, 32'hCAFE_F00D,
                      32'h0040_0024, 6'h0d, 5'd0, 5'd8, 5'd31, 6'h3F, 32'hFFFF_FFFF,
                      32'h1001_0000, 32'hCAFE_F00D, 32'h1001_0000, 32'd2);
        vecs[7]  = mk(1,0,2'b00,1,0,0,0, 32'h0040_0008, 32'h0810_0010,
                      32'h0040_0008, 6'h02, 5'd0, 5'd16, 5'd0, 6'h10, 32'h0000_0010,
                      32'h0040_0008, 32'h0810_0010, 32'h0040_0008, 32'd3);
        vecs[8]  = mk(1,0,2'b10,0,0,0,0, 32'hAAAA_AAAA, 32'h0000_0000,
                      32'h0040_0040, 6'h02, 5'd0, 5'd16, 5'd0, 6'h10, 32'h0000_0010,
                      32'hAAAA_AAAA, 32'h0000_0000, 32'h0040_0040, 32'd3);
        vecs[9]  = mk(0,1,2'b11,0,0,0,1, 32'h0000_0000, 32'h0000_0005,
                      32'h0040_0040, 6'h02, 5'd0, 5'd16, 5'd0, 6'h10, 32'h0000_0010,
                      32'h0000_0000, 32'h0000_0005, 32'h0040_0040, 32'd3);
        vecs[10] = mk(1,0,2'b00,1,0,0,0, 32'h0040_0044, 32'h012A_4020,
                      32'h0040_0044, 6'h00, 5'd9, 5'd10, 5'd8, 6'h20, 32'h0000_4020,
                      32'h0040_0044, 32'h012A_4020, 32'h0040_0044, 32'd4);

        // Reset state while rst_n is held low across an edge
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset_pc",          bus.pc,                32'h0040_0000);
        checkVal("reset_opcode",      {26'b0, bus.Opcode},   32'h0);
        checkVal("reset_instr_count", bus.instr_count,       32'h0);
        checkVal("reset_alu_out",     bus.alu_out,           32'h0);
        checkVal("reset_mdr",         bus.mdr,               32'h0);
        checkVal("reset_mem_addr",    bus.mem_addr,          32'h0040_0000);
        checkVal("reset_imm_ext",     bus.imm_ext,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // FETCH, then pull reset low in the middle of the following cycle
        @(negedge clk);
        driveStim('{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0040_0048, 32'h2008_0005});
        @(posedge clk);
        #1;
        checkVal("prereset_pc",          bus.pc,              32'h0040_0048);
        checkVal("prereset_opcode",      {26'b0, bus.Opcode}, 32'h08);
        checkVal("prereset_instr_count", bus.instr_count,     32'd5);
        driveStim('{1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0040_0060, 32'h0000_0000});
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_reset_pc",          bus.pc,              32'h0040_0000);
        checkVal("async_reset_opcode",      {26'b0, bus.Opcode}, 32'h0);
        checkVal("async_reset_instr_count", bus.instr_count,     32'h0);
        checkVal("async_reset_alu_out",     bus.alu_out,         32'h0);
        checkVal("async_reset_imm_ext",     bus.imm_ext,         32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First FETCH after the mid-cycle reset restarts the count at 1
        applyStimulus(mk(1,0,2'b00,1,0,0,0, 32'h0040_0004, 32'h2008_0005,
                         32'h0040_0004, 6'h08, 5'd0, 5'd8, 5'd0, 6'h05, 32'h0000_0005,
                         32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 32'd1));
        checkOutput("post_reset_fetch");

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/pc_ir_unit.md
Name: pc_ir_unit

Overview:
- Fetch-side datapath block of the multicycle MIPS core.
- Holds the program counter, instruction register (IR), memory data register (MDR) and ALUOut register, plus PC-enable and PC-source selection.
- Driven by the main controller's PCWrite/Branch/PCSrc/IRWrite/IorD/Ori strobes.
- Returns the latched Opcode and instruction fields to the controller and the rest of the datapath.

Parameters:
- WIDTH, 32, datapath width in bits. Only 32 is supported.
- RESET_PC, 32'h0040_0000, PC value after reset.

Ports:
- clk  in  1  system clock; all registers update on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- PCWrite  in  1  unconditional PC load.
- Branch  in  1  conditional PC load, qualified by zero.
- PCSrc  in  2  PC next-value select.
- IRWrite  in  1  IR load enable.
- IorD  in  1  memory address select: 0 = PC, 1 = ALUOut.
- Ori  in  1  immediate extension mode: 1 = zero-extend, 0 = sign-extend.
- zero  in  1  ALU zero flag.
- alu_result  in  WIDTH  combinational ALU result.
- mem_rdata  in  WIDTH  unified memory read data; combinational read of mem_addr.
- mem_addr  out  WIDTH  memory address.
- pc  out  WIDTH  current PC.
- alu_out  out  WIDTH  registered ALU result.
- mdr  out  WIDTH  registered memory data.
- Opcode  out  6  IR[31:26].
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11].
- funct  out  6  IR[5:0].
- imm_ext  out  WIDTH  extended IR[15:0].
- instr_count  out  WIDTH  number of IR loads since reset.

Behaviour:
- Reset: asynchronous on rst_n low, applied immediately, including in the middle of any state.
  - pc = RESET_PC.
  - IR, MDR, alu_out and instr_count = 0, so Opcode = 0 and all IR fields = 0.
- PC enable: pc_en = PCWrite | (Branch & zero).
  - The controller drives X on Branch in don't-care states. The RTL applies no X-masking; the bench must drive known values.
- Next PC, loaded only when pc_en = 1:
  - PCSrc 00: alu_result (PC+4 during FETCH).
  - PCSrc 01: alu_out (branch target computed during DECODE).
  - PCSrc 10: jump target {pc[31:28], IR[25:0], 2'b00}. Uses the current PC, which already holds PC+4 after FETCH.
  - PCSrc 11: hold the PC even when pc_en = 1.
- IR: loads mem_rdata when IRWrite = 1, otherwise holds. instr_count increments by 1 on the same edge and wraps modulo 2^WIDTH.
- MDR loads mem_rdata every cycle. alu_out loads alu_result every cycle. Neither has an enable.
- mem_addr = IorD ? alu_out : pc. It is combinational, so a read issued in cycle n is captured at the edge that ends cycle n.
- FETCH (IRWrite = 1, PCWrite = 1, IorD = 0, PCSrc = 00) at the same edge:
  - IR captures the word at the old PC.
  - PC becomes alu_result.
  - No ordering hazard, because all registers are nonblocking.
- imm_ext = Ori ? {16'b0, IR[15:0]} : {{16{IR[15]}}, IR[15:0]}. It is combinational from the registered IR.
- Branch not taken (Branch = 1, zero = 0, PCWrite = 0): PC holds.
- Latency:
  - Opcode and the other fields are valid one cycle after the IRWrite edge, in time for the DECODE state.
  - alu_out is valid one cycle after alu_result.
- Outputs change only on clock edges or reset, except mem_addr and imm_ext, which are combinational from registers and inputs.

Decomposition:
- Shared package holds:
  - the PCSrc encodings PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_HOLD = 2'b11;
  - the opcode constants OP_RTYPE = 6'h0, OP_J = 6'h2, OP_BEQ = 6'h4, OP_ADDI = 6'h8, OP_ORI = 6'hd.
- One natural sub-module: en_reg, a parameterised-width register with enable and async active-low reset to a parameter value.
  - Instantiated for the PC, IR, MDR, alu_out and instr_count (MDR and alu_out with enable tied high).

Test Plan:
- Reset release, then FETCH with mem_rdata = 32'h2008_0005 and alu_result = 32'h0040_0004 → pc = 0x0040_0004, Opcode = 6'h08, rt = 8, imm_ext = 5, instr_count = 1.
- IR = 32'h3408_FFFF, Ori = 1 → imm_ext = 0x0000_FFFF; Ori = 0 → imm_ext = 0xFFFF_FFFF.
- BEQ with alu_out = 0x0040_0020, Branch = 1, PCSrc = 01: zero = 1 → pc = 0x0040_0020; zero = 0 → pc unchanged.
- Jump with pc = 0x0040_0008, IR = 32'h0810_0010, PCWrite = 1, PCSrc = 10 → pc = 0x0040_0040.
- IorD = 1 with alu_out = 0x1001_0000 → mem_addr = 0x1001_0000. PCSrc = 11 with PCWrite = 1 → pc holds.
- Assert rst_n low mid-cycle between FETCH and DECODE → pc = 0x0040_0000, Opcode = 0 and instr_count = 0 immediately, without waiting for a clock edge.
